inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch unit; consumes the PC stream and returns assembled 32-bit instructions to IF_ID.
- Sits between the PC register, the memory arbiter (8-bit RAM port, 1-cycle read latency) and IF_ID.
- Fetches each instruction as four byte reads, little-endian.
- Raises a stall request while a fetch is in flight and aborts cleanly on a jump/branch flush.

Parameters:
- ADDR_W, 32, width of PC and memory byte address
- INST_W, 32, instruction width (fixed at 4 bytes)

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, synchronous, active-high
- rdy_in  input  1  global ready; low freezes all state
- stall_in  input  6  stall vector; bit 1 high = IF stage frozen
- flush_in  input  1  jump/branch taken; abort current fetch
- pc_in  input  ADDR_W  PC to fetch, sampled in IDLE
- memGrant_in  input  1  arbiter accepts the current byte request
- memData_in  input  8  read byte, valid the cycle after a granted request
- memReq_out  output  1  byte read request
- memAddr_out  output  ADDR_W  byte address of the request
- stallReq_out  output  1  stall request to the stall controller (freezes PC)
- instValid_out  output  1  inst_out/pc_out hold a complete instruction
- inst_out  output  INST_W  assembled instruction
- pc_out  output  ADDR_W  address of inst_out

Behaviour:
- Reset (rst_in=1 at a posedge):
  - State returns to IDLE; issueCnt=0, recvCnt=0, pending=0.
  - All outputs are 0.
  - Reset overrides rdy_in and flush_in, and is effective mid-fetch.
- rdy_in=0: no register changes; memReq_out forced to 0. pending is held.
- States: IDLE, FETCH, DONE.
- IDLE:
  - stallReq_out=0, memReq_out=0.
  - If stall_in[1]=0 and flush_in=0: fetchPc<=pc_in, counters cleared, go to FETCH.
- FETCH:
  - stallReq_out=1.
  - memReq_out=1 while issueCnt<4; memAddr_out=fetchPc+issueCnt (mod 2^ADDR_W, so wrap at 0xFFFFFFFF is allowed).
  - Request with memGrant_in=1: issueCnt++, pending<=1 for the next cycle.
  - Request with memGrant_in=0: address held unchanged, no increment, pending<=0.
  - When pending=1: memData_in is stored into byte lane recvCnt (lane 0 = bits 7:0) and recvCnt++.
  - When the 4th byte is stored: go to DONE.
- DONE:
  - instValid_out=1, inst_out=assembled word, pc_out=fetchPc; stallReq_out=0, memReq_out=0.
  - If stall_in[1]=0: go to IDLE at the next edge. instValid_out is therefore a one-cycle pulse when unstalled.
  - If stall_in[1]=1: DONE and all outputs are held.
- Latency with continuous grant: pc sampled in IDLE at cycle 0; requests at cycles 1-4; bytes at cycles 2-5; instValid_out high in cycle 6.
- Each extra denied-grant cycle adds one cycle of latency.
- flush_in=1, any state (priority below reset only):
  - Next state IDLE; counters and pending cleared; instValid_out<=0.
  - memReq_out is 0 during the flush cycle.
  - A byte returning in the cycle after flush, from an already-granted request, is discarded.
  - The new pc_in is sampled in the first IDLE cycle with flush_in=0.
- inst_out and pc_out keep their last values after leaving DONE; instValid_out is 0 outside DONE.
- At most one outstanding granted request; byte order is strictly lanes 0→3.

Test Plan:
- Basic fetch: reset, pc_in=0x00001000, grant always 1, RAM bytes 0x13,0x05,0x10,0x00 → requests to 0x1000-0x1003; instValid_out high in cycle 6 with inst_out=0x00100513, pc_out=0x1000; stallReq_out high in cycles 1-5.
- Grant gaps: same fetch, memGrant_in=0 on the 2nd request for 2 cycles → memAddr_out holds 0x1001; instValid_out arrives in cycle 8 with the same inst_out.
- Flush mid-fetch: flush_in pulsed after 2 bytes are received, then pc_in=0x2000 → no instValid_out for 0x1000; the stray byte is discarded; next fetch reads 0x2000-0x2003 and returns the correct word.
- Downstream stall: stall_in[1]=1 for 3 cycles on entering DONE → instValid_out, inst_out and pc_out held for 4 cycles; no new requests until release.
- rdy_in low: drop rdy_in for 2 cycles mid-FETCH → memReq_out=0 and counters frozen; after resume, the final inst_out is identical to the uninterrupted case.
- Reset mid-fetch: rst_in=1 while issueCnt=2 → next cycle all outputs 0 and state IDLE; the following fetch of 0xFFFFFFFE wraps its addresses to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Memory-side byte bus between the instruction-fetch unit and the memory arbiter.
//   memReq_out  : byte read request (fetch unit -> arbiter)
//   memAddr_out : byte address of the request
//   memGrant_in : arbiter accepts the current request this cycle
//   memData_in  : read byte, valid the cycle after a granted request
// The master modport is the fetch unit; the slave modport is the arbiter/RAM.
interface inst_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              memReq_out;
    logic [ADDR_W-1:0] memAddr_out;
    logic              memGrant_in;
    logic [7:0]        memData_in;

    modport master (
        output memReq_out,
        output memAddr_out,
        input  memGrant_in,
        input  memData_in
    );

    modport slave (
        input  memReq_out,
        input  memAddr_out,
        output memGrant_in,
        output memData_in
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch unit. Takes the PC, reads the instruction as four
// little-endian byte reads over an 8-bit memory port (1-cycle read latency),
// and hands the assembled 32-bit word to IF_ID.
//   clk_in, rst_in  : clock, synchronous active-high reset
//   rdy_in          : global ready, low freezes every register
//   stall_in[1]     : IF stage frozen (gates PC sampling and DONE exit)
//   flush_in        : jump/branch taken, abort the current fetch
//   pc_in           : PC to fetch, sampled in IDLE
//   mem_bus         : byte request/grant/data bus to the arbiter
//   stallReq_out    : high while a fetch is in flight
//   instValid_out   : inst_out/pc_out hold a complete instruction
//   inst_out, pc_out: assembled instruction and its address
module inst_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [5:0]        stall_in,
    input  logic              flush_in,
    input  logic [ADDR_W-1:0] pc_in,
    inst_fetch_if.master      mem_bus,
    output logic              stallReq_out,
    output logic              instValid_out,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [2:0]          issue_cnt_q, issue_cnt_d;
    logic [1:0]          recv_cnt_q, recv_cnt_d;
    logic                pending_q, pending_d;
    logic [2:0][7:0]     lane_q, lane_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d;

    logic                if_stall;
    logic                req;
    logic                stall_unused;

    assign if_stall     = stall_in[1];
    assign stall_unused = ^{stall_in[5:2], stall_in[0]};

    // Request is suppressed by a frozen pipeline or a flush in the same cycle.
    assign req = (state_q == FETCH) && (issue_cnt_q < 3'd4) && rdy_in && !flush_in;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        pending_d   = pending_q;
        lane_d      = lane_q;
        inst_d      = inst_q;
        pc_out_d    = pc_out_q;

        if (flush_in) begin
            // Clearing pending drops the byte of an already-granted request.
            state_d     = IDLE;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 2'd0;
            pending_d   = 1'b0;
        end else if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (!if_stall) begin
                        fetch_pc_d  = pc_in;
                        issue_cnt_d = 3'd0;
                        recv_cnt_d  = 2'd0;
                        pending_d   = 1'b0;
                        state_d     = FETCH;
                    end
                end
                FETCH: begin
                    pending_d = req && mem_bus.memGrant_in;
                    if (req && mem_bus.memGrant_in) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                    end
                    if (pending_q) begin
                        if (recv_cnt_q == 2'd3) begin
                            // Last byte goes straight into the top lane of the output word.
                            inst_d   = {mem_bus.memData_in, lane_q};
                            pc_out_d = fetch_pc_q;
                            state_d  = DONE;
                        end else begin
                            lane_d[recv_cnt_q] = mem_bus.memData_in;
                            recv_cnt_d         = recv_cnt_q + 2'd1;
                        end
                    end
                end
                DONE: begin
                    if (!if_stall) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            fetch_pc_q  <= '0;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 2'd0;
            pending_q   <= 1'b0;
            inst_q      <= '0;
            pc_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            pending_q   <= pending_d;
            inst_q      <= inst_d;
            pc_out_q    <= pc_out_d;
        end
        // Assembly lanes carry data only and need no reset.
        lane_q <= lane_d;
    end

    assign mem_bus.memReq_out  = req;
    assign mem_bus.memAddr_out = fetch_pc_q + ADDR_W'(issue_cnt_q);
    assign stallReq_out        = (state_q == FETCH);
    assign instValid_out       = (state_q == DONE);
    assign inst_out            = inst_q;
    assign pc_out              = pc_out_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [5:0]  stall_in;
    logic        flush_in;
    logic [31:0] pc_in;
    logic        stallReq_out;
    logic        instValid_out;
    logic [31:0] inst_out;
    logic [31:0] pc_out;

    inst_fetch_if #(.ADDR_W(32)) mem_bus ();

    inst_fetch #(.ADDR_W(32), .INST_W(32)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .stall_in      (stall_in),
        .flush_in      (flush_in),
        .pc_in         (pc_in),
        .mem_bus       (mem_bus),
        .stallReq_out  (stallReq_out),
        .instValid_out (instValid_out),
        .inst_out      (inst_out),
        .pc_out        (pc_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference memory: explicit bytes where a test needs them, a hash elsewhere.
    logic [7:0]  ram [bit [31:0]];
    logic [63:0] exp_q [$];   // {pc, instruction} per expected completion
    logic [31:0] addr_q [$];  // expected byte addresses of granted requests

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ {a[28:24], a[31:29]} ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {rd(pc + 32'd3), rd(pc + 32'd2), rd(pc + 32'd1), rd(pc)};
    endfunction

    task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: a byte granted in one cycle is presented in the next.
    logic        g_req;
    logic [31:0] g_addr;
    initial begin
        mem_bus.memData_in = 8'h00;
        forever begin
            @(negedge clk);
            g_req  = mem_bus.memReq_out && mem_bus.memGrant_in;
            g_addr = mem_bus.memAddr_out;
            @(posedge clk);
            #1;
            if (g_req) mem_bus.memData_in = rd(g_addr);
        end
    end

    // Monitor: checks granted addresses and every cycle of a valid instruction.
    logic        prev_v = 1'b0;
    logic [63:0] cur_exp = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (mem_bus.memReq_out && mem_bus.memGrant_in) begin
                if (addr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_grant: addr %h with none expected", mem_bus.memAddr_out);
                end else begin
                    chk_w("grant_addr", mem_bus.memAddr_out, addr_q.pop_front());
                end
            end
            if (instValid_out) begin
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_valid: inst %h pc %h with none expected", inst_out, pc_out);
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                end
                chk_w("inst_out", inst_out, cur_exp[31:0]);
                chk_w("pc_out", pc_out, cur_exp[63:32]);
            end
            prev_v = instValid_out;
        end
    end

    // Cycle-exact fetch starting with the DUT in IDLE; cycle 0 samples pc.
    task automatic trace_fetch(input logic [31:0] pc, input logic [15:0] gnt_m,
                               input logic [15:0] rdy_m, input int vcyc, input int hold);
        int   issued = 0;
        logic exp_req;
        exp_q.push_back({pc, word_at(pc)});
        for (int i = 0; i < 4; i++) addr_q.push_back(pc + 32'(i));
        pc_in    = pc;
        flush_in = 1'b0;
        for (int k = 0; k <= vcyc + hold; k++) begin
            mem_bus.memGrant_in = gnt_m[k];
            rdy_in              = rdy_m[k];
            stall_in            = {4'b0, (k >= 1 && k < vcyc + hold), 1'b0};
            @(negedge clk);
            chk_b("stall_req", stallReq_out, (k >= 1 && k < vcyc));
            chk_b("inst_valid", instValid_out, (k >= vcyc));
            exp_req = (k >= 1) && (k < vcyc) && (issued < 4) && rdy_m[k];
            chk_b("mem_req", mem_bus.memReq_out, exp_req);
            if (exp_req) begin
                chk_w("mem_addr", mem_bus.memAddr_out, pc + 32'(issued));
                if (gnt_m[k]) issued++;
            end
            tick();
        end
        stall_in = 6'h02;
        rdy_in   = 1'b1;
    endtask

    // Randomized fetch: random grant, ready, stall and occasional flush.
    task automatic run_fetch(input logic [31:0] pc);
        bit done = 1'b0;
        int k = 0;
        exp_q.push_back({pc, word_at(pc)});
        for (int i = 0; i < 4; i++) addr_q.push_back(pc + 32'(i));
        pc_in               = pc;
        stall_in            = 6'h00;
        rdy_in              = 1'b1;
        flush_in            = 1'b0;
        mem_bus.memGrant_in = ($urandom_range(0, 3) != 0);
        while (!done && k < 400) begin
            @(negedge clk);
            if (flush_in) begin
                if (!instValid_out) void'(exp_q.pop_back());
                done = 1'b1;
            end else if (instValid_out && rdy_in && !stall_in[1]) begin
                done = 1'b1;
            end
            tick();
            k++;
            if (done) begin
                flush_in = 1'b0;
                rdy_in   = 1'b1;
                stall_in = 6'h02;
                addr_q.delete();
            end else begin
                rdy_in              = ($urandom_range(0, 9) != 0);
                mem_bus.memGrant_in = ($urandom_range(0, 3) != 0);
                stall_in            = {4'b0, 1'($urandom_range(0, 1)), 1'b0};
                flush_in            = rdy_in && ($urandom_range(0, 39) == 0);
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL fetch_timeout: pc %h not finished after %0d cycles", pc, k);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk_b({tag, "_valid"}, instValid_out, 1'b0);
        chk_b({tag, "_stall_req"}, stallReq_out, 1'b0);
        chk_b({tag, "_mem_req"}, mem_bus.memReq_out, 1'b0);
        chk_w({tag, "_mem_addr"}, mem_bus.memAddr_out, 32'h0);
        chk_w({tag, "_inst"}, inst_out, 32'h0);
        chk_w({tag, "_pc"}, pc_out, 32'h0);
    endtask

    initial begin
        logic [31:0] rpc;
        ram[32'h1000] = 8'h13;
        ram[32'h1001] = 8'h05;
        ram[32'h1002] = 8'h10;
        ram[32'h1003] = 8'h00;

        // Reset wins over rdy_in=0 and flush_in=1.
        rst_in              = 1'b1;
        rdy_in              = 1'b0;
        flush_in            = 1'b1;
        stall_in            = 6'h02;
        pc_in               = 32'h0;
        mem_bus.memGrant_in = 1'b0;
        tick();
        tick();
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        @(negedge clk);
        chk_zero_outputs("reset");
        tick();

        // Basic fetch, continuous grant: valid in cycle 6.
        trace_fetch(32'h0000_1000, 16'hFFFF, 16'hFFFF, 6, 0);
        @(negedge clk);
        chk_w("basic_inst_kept", inst_out, 32'h0010_0513);
        chk_w("basic_pc_kept", pc_out, 32'h0000_1000);
        tick();

        // Second request denied for two cycles: valid in cycle 8.
        trace_fetch(32'h0000_1000, 16'hFFF3, 16'hFFFF, 8, 0);
        tick();

        // Downstream stall for 3 cycles in DONE: held for 4 cycles.
        trace_fetch(32'h0000_1000, 16'hFFFF, 16'hFFFF, 6, 3);
        tick();

        // rdy_in low in cycles 2-3: everything shifts by two.
        trace_fetch(32'h0000_1000, 16'hFFFF, 16'hFFF3, 8, 0);
        tick();

        // Flush after two bytes received; the in-flight third byte is dropped.
        for (int i = 0; i < 4; i++) addr_q.push_back(32'h1000 + 32'(i));
        pc_in               = 32'h0000_1000;
        stall_in            = 6'h00;
        mem_bus.memGrant_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_b("flush_pre_valid", instValid_out, 1'b0);
            tick();
        end
        flush_in = 1'b1;
        @(negedge clk);
        chk_b("flush_mem_req", mem_bus.memReq_out, 1'b0);
        chk_b("flush_valid", instValid_out, 1'b0);
        tick();
        flush_in = 1'b0;
        addr_q.delete();
        trace_fetch(32'h0000_2000, 16'hFFFF, 16'hFFFF, 6, 0);
        tick();

        // Reset mid-fetch with two requests issued, then a wrapping fetch.
        for (int i = 0; i < 4; i++) addr_q.push_back(32'h3000 + 32'(i));
        pc_in               = 32'h0000_3000;
        stall_in            = 6'h00;
        mem_bus.memGrant_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tick();
        end
        rst_in = 1'b1;
        @(negedge clk);
        tick();
        rst_in   = 1'b0;
        stall_in = 6'h02;
        addr_q.delete();
        @(negedge clk);
        chk_zero_outputs("mid_reset");
        tick();
        trace_fetch(32'hFFFF_FFFE, 16'hFFFF, 16'hFFFF, 6, 0);
        tick();

        // Randomized fetches against the reference memory.
        for (int n = 0; n < 60; n++) begin
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                              : 32'($urandom);
            run_fetch(rpc);
        end
        repeat (3) tick();
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_valid: %0d expected instructions never returned", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
